// File: rtl/base_sys_nios2_cpu_cpu_debug_action_sched_pkg.sv
// Shared constants and types for the debug action scheduler: source indices,
// FSM state encoding and payload width.
package base_sys_nios2_cpu_cpu_debug_action_sched_pkg;

  localparam int N_SRC = 6;
  localparam int IDX_W = 3;
  localparam int JDO_W = 38;

  localparam logic [IDX_W-1:0] SRC_OCIMEM_B  = 3'd0;
  localparam logic [IDX_W-1:0] SRC_OCIMEM_A  = 3'd1;
  localparam logic [IDX_W-1:0] SRC_BREAK_A   = 3'd2;
  localparam logic [IDX_W-1:0] SRC_BREAK_B   = 3'd3;
  localparam logic [IDX_W-1:0] SRC_BREAK_C   = 3'd4;
  localparam logic [IDX_W-1:0] SRC_TRACECTRL = 3'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/base_sys_nios2_cpu_cpu_debug_prio_pick.sv
// Fixed-priority picker: the lowest-index request wins, reported both as a
// one-hot grant and as a binary source index.
module base_sys_nios2_cpu_cpu_debug_prio_pick
  import base_sys_nios2_cpu_cpu_debug_action_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt = N_SRC'(1) << i;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/base_sys_nios2_cpu_cpu_debug_action_sched.sv
// Debug action scheduler: captures take_action strobes into per-source slots
// and issues them one at a time, in fixed priority, to the OCI datapath.
module base_sys_nios2_cpu_cpu_debug_action_sched
  import base_sys_nios2_cpu_cpu_debug_action_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] act_pulse,
  input  logic [JDO_W-1:0] jdo,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [IDX_W-1:0] cmd_code,
  output logic [JDO_W-1:0] cmd_data,
  input  logic             cmd_done,
  input  logic             cmd_err,
  input  logic             clr_status,
  output logic             busy,
  output logic [N_SRC-1:0] pending,
  output logic             ovf,
  output logic             tmo,
  output logic             err
);

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   pending_q;
  logic [JDO_W-1:0]   slot_q [N_SRC];
  logic [N_SRC-1:0]   gnt_q;
  logic [IDX_W-1:0]   cmd_code_q;
  logic [JDO_W-1:0]   cmd_data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q, tmo_q, err_q;

  logic [N_SRC-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               arb_load;
  logic               handshake;
  logic [N_SRC-1:0]   grant_clr;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;
  logic               ovf_set, tmo_set, err_set;

  base_sys_nios2_cpu_cpu_debug_prio_pick u_pick (
    .req (pending_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Handshake: cmd_valid is high for the whole ISSUE state and cmd_code/cmd_data
  // do not change while it is high; a transfer happens on any edge where
  // cmd_valid and cmd_ready are both high, and cmd_valid never drops before it.
  assign arb_load    = (state_q == IDLE) && (|pending_q);
  assign handshake   = (state_q == ISSUE) && cmd_ready;
  assign grant_clr   = handshake ? gnt_q : '0;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (state_q == WAIT_DONE) && !cmd_done &&
                       (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // A pulse on the source being granted this edge re-arms it without an overflow.
  assign ovf_set = |(act_pulse & pending_q & ~grant_clr);
  assign tmo_set = timeout_hit;
  assign err_set = (state_q == WAIT_DONE) && cmd_done && cmd_err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (|pending_q) state_d = ISSUE;
      ISSUE:     if (cmd_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (cmd_done || timeout_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= (pending_q & ~grant_clr) | act_pulse;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (reset)             slot_q[i] <= '0;
      else if (act_pulse[i]) slot_q[i] <= jdo;
    end
  end

  // The command is frozen at arbitration, so later writes to the slot only
  // affect the next issue of that source.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= '0;
      cmd_code_q <= '0;
      cmd_data_q <= '0;
    end else if (arb_load) begin
      gnt_q      <= pick_gnt;
      cmd_code_q <= pick_idx;
      cmd_data_q <= slot_q[pick_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                             cnt_q <= '0;
    else if (state_q == WAIT_DONE && state_d == WAIT_DONE) cnt_q <= cnt_inc;
    else                                                   cnt_q <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr_status);
      tmo_q <= tmo_set | (tmo_q & ~clr_status);
      err_q <= err_set | (err_q & ~clr_status);
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_code  = cmd_code_q;
  assign cmd_data  = cmd_data_q;
  assign pending   = pending_q;
  assign busy      = (state_q != IDLE) || (|pending_q);
  assign ovf       = ovf_q;
  assign tmo       = tmo_q;
  assign err       = err_q;

endmodule

// File: tb/tb_base_sys_nios2_cpu_cpu_debug_action_sched.sv
// Bench for the debug action scheduler: directed scenarios plus random traffic,
// all compared every cycle against a behavioural model and a command scoreboard.
module tb_base_sys_nios2_cpu_cpu_debug_action_sched;
  import base_sys_nios2_cpu_cpu_debug_action_sched_pkg::*;

  localparam int TMO = 255;

  logic        clk;
  logic        reset;
  logic [5:0]  act_pulse;
  logic [37:0] jdo;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_code;
  logic [37:0] cmd_data;
  logic        cmd_done;
  logic        cmd_err;
  logic        clr_status;
  logic        busy;
  logic [5:0]  pending;
  logic        ovf, tmo, err;

  base_sys_nios2_cpu_cpu_debug_action_sched #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .act_pulse  (act_pulse),
    .jdo        (jdo),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_data   (cmd_data),
    .cmd_done   (cmd_done),
    .cmd_err    (cmd_err),
    .clr_status (clr_status),
    .busy       (busy),
    .pending    (pending),
    .ovf        (ovf),
    .tmo        (tmo),
    .err        (err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / counters ----------------
  int          n_tests;
  int          n_fail;
  logic [40:0] exp_q[$];
  int          obs_codes[$];
  int          hs_cnt[6];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing outstanding, 1 = command offered, 2 = awaiting completion
  int          m_phase;
  logic [5:0]  m_pend;
  logic [37:0] m_slot[6];
  int          m_code;
  logic [37:0] m_data;
  int          m_wait;
  bit          m_ovf, m_tmo, m_err;

  task automatic model_step();
    logic [5:0] clr_v;
    bit ovf_s, tmo_s, err_s;
    int w;
    if (reset) begin
      m_phase = 0;
      m_pend  = '0;
      for (int i = 0; i < 6; i++) m_slot[i] = '0;
      m_code = 0;
      m_data = '0;
      m_wait = 0;
      m_ovf = 0; m_tmo = 0; m_err = 0;
      exp_q.delete();
      return;
    end
    clr_v = ((m_phase == 1) && cmd_ready) ? (6'b1 << m_code) : 6'b0;
    ovf_s = 0; tmo_s = 0; err_s = 0;
    case (m_phase)
      0: if (m_pend != 0) begin
        w = 0;
        for (int i = 5; i >= 0; i--) if (m_pend[i]) w = i;
        m_code  = w;
        m_data  = m_slot[w];
        m_phase = 1;
        exp_q.push_back({3'(w), m_slot[w]});
      end
      1: if (cmd_ready) begin
        m_phase = 2;
        m_wait  = 0;
      end
      default: begin
        if (cmd_done) begin
          m_phase = 0;
          err_s   = cmd_err;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_phase = 0;
            tmo_s   = 1;
          end
        end
      end
    endcase
    for (int i = 0; i < 6; i++) begin
      if (act_pulse[i] && m_pend[i] && !clr_v[i]) ovf_s = 1;
      m_pend[i] = (m_pend[i] && !clr_v[i]) || act_pulse[i];
      if (act_pulse[i]) m_slot[i] = jdo;
    end
    m_ovf = ovf_s || (m_ovf && !clr_status);
    m_tmo = tmo_s || (m_tmo && !clr_status);
    m_err = err_s || (m_err && !clr_status);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [40:0] e;
    @(negedge clk);
    check("cmd_valid", cmd_valid, m_phase == 1);
    check("pending", pending, m_pend);
    check("busy", busy, (m_phase != 0) || (m_pend != 0));
    check("ovf", ovf, m_ovf);
    check("tmo", tmo, m_tmo);
    check("err", err, m_err);
    if (m_phase == 1) begin
      check("cmd_code", cmd_code, m_code);
      check("cmd_data", cmd_data, m_data);
    end
    if (cmd_valid && cmd_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_cmd", {cmd_code, cmd_data}, 41'h0);
      end else begin
        e = exp_q.pop_front();
        check("sb_cmd", {cmd_code, cmd_data}, e);
      end
      obs_codes.push_back(int'(cmd_code));
      hs_cnt[cmd_code]++;
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n;
    n = 0;
    while (m_phase != p && n < budget) begin
      tick();
      n++;
    end
    check("wait_phase_bound", m_phase, p);
  endtask

  task automatic pulse(input logic [5:0] a, input logic [37:0] d);
    act_pulse = a;
    jdo       = d;
    tick();
    act_pulse = '0;
  endtask

  task automatic done_pulse(input logic e);
    cmd_done = 1'b1;
    cmd_err  = e;
    tick();
    cmd_done = 1'b0;
    cmd_err  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base3;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 6; i++) hs_cnt[i] = 0;
    reset = 1'b1; act_pulse = '0; jdo = '0; cmd_ready = 1'b0;
    cmd_done = 1'b0; cmd_err = 1'b0; clr_status = 1'b0;
    repeat (3) begin
      @(posedge clk);
      model_step();
    end
    #1;
    act_pulse = 6'h3f;  // must be ignored while reset is high
    tick();
    act_pulse = '0;
    reset = 1'b0;
    check("rst_pending", pending, 6'h00);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {ovf, tmo, err}, 3'b000);
    check("rst_code_data", {cmd_code, cmd_data}, 41'h0);

    // single request, latency
    cmd_ready = 1'b1;
    pulse(6'b000100, 38'h2A_1234_5678);
    check("t25_pend", pending, 6'b000100);
    check("t25_valid_early", cmd_valid, 1'b0);
    tick();
    check("t25_valid", cmd_valid, 1'b1);
    check("t25_code", cmd_code, 3'd2);
    check("t25_data", cmd_data, 38'h2A_1234_5678);
    tick();
    check("t25_pend_clr", pending, 6'h00);
    done_pulse(1'b0);
    check("t25_busy", busy, 1'b0);
    check("t25_count", hs_cnt[2], 1);

    // simultaneous requests, fixed priority
    obs_codes.delete();
    pulse(6'b100011, 38'h15_5555_AAAA);
    for (int g = 0; g < 3; g++) begin
      wait_phase(2, 20);
      tick();
      tick();
      done_pulse(1'b0);
    end
    tick();
    check("t26_ngrants", obs_codes.size(), 3);
    if (obs_codes.size() == 3) begin
      check("t26_order0", obs_codes[0], 0);
      check("t26_order1", obs_codes[1], 1);
      check("t26_order2", obs_codes[2], 5);
    end
    check("t26_pend", pending, 6'h00);

    // overwrite while busy
    base3 = hs_cnt[3];
    pulse(6'b000001, 38'h00_0000_0077);
    wait_phase(2, 20);
    pulse(6'b001000, 38'd1);
    pulse(6'b001000, 38'd2);
    check("t27_ovf", ovf, 1'b1);
    check("t27_pend", pending, 6'b001000);
    done_pulse(1'b0);
    wait_phase(2, 20);
    check("t27_code", cmd_code, 3'd3);
    check("t27_data", cmd_data, 38'd2);
    done_pulse(1'b0);
    repeat (3) tick();
    check("t27_once", hs_cnt[3] - base3, 1);

    // pulse on the granted source at its own grant edge
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t27b_ovf_clr", ovf, 1'b0);
    pulse(6'b000001, 38'h0A);
    wait_phase(1, 10);
    pulse(6'b000001, 38'h0B);
    check("t27b_ovf", ovf, 1'b0);
    check("t27b_pend", pending, 6'b000001);
    done_pulse(1'b0);
    wait_phase(2, 10);
    check("t27b_code", cmd_code, 3'd0);
    check("t27b_data", cmd_data, 38'h0B);
    done_pulse(1'b0);

    // backpressure then timeout
    cmd_ready = 1'b0;
    pulse(6'b000010, 38'h3F_0000_1111);
    wait_phase(1, 10);
    pulse(6'b010000, 38'h01_2345_6789);
    for (int k = 0; k < 10; k++) begin
      check("t28_valid_hold", cmd_valid, 1'b1);
      check("t28_code_hold", cmd_code, 3'd1);
      check("t28_data_hold", cmd_data, 38'h3F_0000_1111);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    check("t28_pend4", pending, 6'b010000);
    repeat (TMO - 1) tick();
    check("t28_tmo_early", tmo, 1'b0);
    tick();
    check("t28_tmo", tmo, 1'b1);
    check("t28_idle", cmd_valid, 1'b0);
    tick();
    check("t28_next_valid", cmd_valid, 1'b1);
    check("t28_next_code", cmd_code, 3'd4);
    check("t28_next_data", cmd_data, 38'h01_2345_6789);
    tick();
    done_pulse(1'b0);

    // error flag, clear, reset mid-command
    pulse(6'b000100, 38'h22);
    wait_phase(2, 10);
    done_pulse(1'b1);
    check("t29_err", err, 1'b1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t29_err_clr", err, 1'b0);
    check("t29_tmo_clr", tmo, 1'b0);
    pulse(6'b000001, 38'h33);
    wait_phase(2, 10);
    pulse(6'b010000, 38'h44);
    check("t29_pend_pre", pending, 6'b010000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t29_rst_pend", pending, 6'h00);
    check("t29_rst_valid", cmd_valid, 1'b0);
    check("t29_rst_busy", busy, 1'b0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 6; b++) act_pulse[b] = ($urandom_range(0, 15) == 0);
      jdo        = 38'({$urandom(), $urandom()});
      cmd_ready  = ($urandom_range(0, 3) != 0);
      cmd_done   = ($urandom_range(0, 5) == 0);
      cmd_err    = $urandom_range(0, 1);
      clr_status = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    act_pulse = '0; reset = 1'b0; clr_status = 1'b0; cmd_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cmd_done = $urandom_range(0, 1);
      cmd_err  = 1'b0;
      tick();
    end
    cmd_done = 1'b0;
    tick();
    check("drain_busy", busy, 1'b0);
    check("drain_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/base_sys_nios2_cpu_cpu_debug_action_sched.md
BASE_SYS_NIOS2_CPU_CPU_DEBUG_ACTION_SCHED -- requirements
Module: base_sys_nios2_cpu_cpu_debug_action_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles spent in WAIT_DONE.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the timeout counter width; TIMEOUT_CYCLES < 2^CNT_W.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- act_pulse  in  6  one-cycle take_action strobes, one bit per source: [0] ocimem_b, [1] ocimem_a, [2] break_a, [3] break_b, [4] break_c, [5] tracectrl.
- jdo  in  38  debug payload, valid in the same cycle as act_pulse.
- cmd_valid  out  1  command offered to the OCI datapath.
- cmd_ready  in  1  datapath accepts the command.
- cmd_code  out  3  source index of the granted command.
- cmd_data  out  38  payload latched for the granted source.
- cmd_done  in  1  datapath completion strobe.
- cmd_err  in  1  error qualifier, sampled with cmd_done.
- clr_status  in  1  clears the sticky flags.
- busy  out  1  high when the FSM is not IDLE or any source is pending.
- pending  out  6  per-source pending bits.
- ovf  out  1  sticky: a request was overwritten before it was granted.
- tmo  out  1  sticky: WAIT_DONE expired.
- err  out  1  sticky: cmd_done arrived with cmd_err high.

Function
REQ-005 Each source SHALL have a capture slot: on act_pulse[i], set pending[i] and latch jdo into slot i on the same edge.
REQ-006 If act_pulse[i] arrives while pending[i] is already set and not being granted, the slot SHALL take the new jdo and set ovf.
REQ-007 Simultaneous pulses on different sources SHALL all be captured in the same cycle, with no loss.
REQ-008 The arbiter SHALL use fixed priority, lowest index first: ocimem_b > ocimem_a > break_a > break_b > break_c > tracectrl.
REQ-009 The FSM SHALL have three states: IDLE, ISSUE and WAIT_DONE.
REQ-010 IDLE -> ISSUE SHALL occur on the first edge where pending != 0. At that edge, cmd_code and cmd_data SHALL be registered from the winning slot.
REQ-011 In ISSUE, cmd_valid SHALL be 1, and cmd_code/cmd_data SHALL be held stable until cmd_ready is high.
REQ-012 On the edge where cmd_valid and cmd_ready are both high:
- the granted pending bit SHALL clear;
- the FSM SHALL go to WAIT_DONE;
- the timeout counter SHALL load 0.
REQ-013 If act_pulse for the granted source coincides with the grant edge, pending SHALL remain set with the new data and ovf SHALL NOT set.
REQ-014 In WAIT_DONE, cmd_done SHALL return the FSM to IDLE on the next edge; if cmd_err is high at that edge, err SHALL be set.
REQ-015 In WAIT_DONE, the counter SHALL increment each cycle without cmd_done. When it reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE and set tmo.
REQ-016 cmd_done when the FSM is not in WAIT_DONE SHALL be ignored.
REQ-017 Latency from act_pulse on an idle block with cmd_ready tied high:
- cmd_valid high 2 cycles later;
- grant on the edge at the end of that cycle.
REQ-018 A new arbitration SHALL occur only from IDLE; there SHALL be at most one outstanding command.
REQ-019 clr_status SHALL clear ovf, tmo and err. If a set condition occurs in the same cycle, the set SHALL win.

Reset
REQ-020 Reset SHALL put the FSM in IDLE and set to 0: pending, all slots, cmd_valid, cmd_code, cmd_data, counter, ovf, tmo and err.
REQ-021 Reset asserted during ISSUE or WAIT_DONE SHALL abandon the command; cmd_valid SHALL be 0 in the first cycle after the reset edge.
REQ-022 act_pulse SHALL be ignored in any cycle in which reset is high.

Structure
REQ-023 A shared package SHALL hold:
- the source index constants SRC_OCIMEM_B..SRC_TRACECTRL (0..5);
- the state enum {IDLE, ISSUE, WAIT_DONE};
- the payload width constant JDO_W = 38.
REQ-024 The fixed-priority picker (6-bit request in, one-hot grant and 3-bit index out) SHALL be a sub-module named base_sys_nios2_cpu_cpu_debug_prio_pick; all other logic stays in the top module.

Verification
REQ-025 Single request: act_pulse=6'b000100 with jdo=38'h2A_1234_5678, cmd_ready=1 -> one transfer with cmd_code=2 and cmd_data=38'h2A_1234_5678; after cmd_done, busy=0.
REQ-026 Simultaneous requests: act_pulse=6'b100011 in one cycle, cmd_ready=1, cmd_done 3 cycles after each grant -> grants in order codes 0, 1, 5, and pending returns to 0.
REQ-027 Overwrite: two pulses on bit 3 (jdo=1, then jdo=2) while the FSM is in WAIT_DONE on code 0 -> ovf=1 and code 3 issues once with cmd_data=2. A separate run with a pulse on bit 0 at its own grant edge -> code 0 issues again and ovf=0.
REQ-028 Backpressure and timeout: cmd_ready low for 10 cycles -> cmd_valid, cmd_code and cmd_data stable throughout. Then no cmd_done for TIMEOUT_CYCLES=255 -> tmo=1, FSM IDLE, next pending request issued.
REQ-029 Error and reset: cmd_done with cmd_err=1 -> err=1; clr_status -> err=0. Reset asserted in WAIT_DONE with pending=6'b010000 -> next cycle pending=0, cmd_valid=0, busy=0.
